// File: rtl/ni_gen2.sv
// ni_gen2: GPU <-> leaf-router network interface with ID translation, filtering and statistics
// Ports: clk, reset (async, active-high)
//   gpu_data_in/gpu_valid_in/gpu_ready_out       GPU -> NI TX flits {dest_id, payload}
//   router_data_out/router_valid_out/router_ready_in  NI -> router {routing_addr, payload}
//   router_data_in/router_valid_in/router_ready_out   router -> NI RX flits
//   gpu_data_out/gpu_valid_out/gpu_ready_in      NI -> GPU {gpu_id, payload}
//   tx_level/rx_level FIFO occupancy (output register excluded)
//   drop_cnt/misroute_cnt saturating event counters
module ni_gen2_q #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_ready,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = DEPTH[AW:0];
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_cnt;
  logic              w_push, w_pop;
  assign o_ready = r_cnt != L_FULL;
  assign w_push  = i_push && o_ready;
  // output register refills whenever it is empty or being drained this cycle
  assign w_pop   = (!o_valid || i_ready) && r_cnt != '0;
  assign o_level = r_cnt;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_rp   <= r_rp + 1'b1;
        o_data <= r_mem[r_rp];
      end
      o_valid <= w_pop || (o_valid && !i_ready);
      r_cnt   <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
endmodule

module ni_gen2 #(
  parameter int GPU_ID      = 14,
  parameter int DATA_W      = 16,
  parameter int ID_W        = 6,
  parameter int NUM_GPUS    = 32,
  parameter int ADDR_OFFSET = 3,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             gpu_data_in,
  input  logic                          gpu_valid_in,
  output logic                          gpu_ready_out,
  output logic [DATA_W-1:0]             router_data_out,
  output logic                          router_valid_out,
  input  logic                          router_ready_in,
  input  logic [DATA_W-1:0]             router_data_in,
  input  logic                          router_valid_in,
  output logic                          router_ready_out,
  output logic [DATA_W-1:0]             gpu_data_out,
  output logic                          gpu_valid_out,
  input  logic                          gpu_ready_in,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic [CNT_W-1:0]              misroute_cnt
);
  localparam int PW = DATA_W - ID_W;
  localparam logic [ID_W-1:0] L_OFF   = ID_W'(ADDR_OFFSET);
  localparam logic [ID_W-1:0] L_MAX   = ID_W'(NUM_GPUS);
  localparam logic [ID_W-1:0] L_LOCAL = ID_W'(GPU_ID + ADDR_OFFSET);
  logic [ID_W-1:0]  w_dest, w_hdr;
  logic             w_dest_ok, w_hit, w_tx_acc, w_rx_acc;
  logic [CNT_W-1:0] r_drop, r_mis;
  assign w_dest    = gpu_data_in[DATA_W-1 -: ID_W];
  assign w_hdr     = router_data_in[DATA_W-1 -: ID_W];
  assign w_dest_ok = w_dest != '0 && w_dest <= L_MAX;
  assign w_hit     = w_hdr == L_LOCAL;
  assign w_tx_acc  = gpu_valid_in && gpu_ready_out;
  assign w_rx_acc  = router_valid_in && router_ready_out;
  assign drop_cnt     = r_drop;
  assign misroute_cnt = r_mis;
  ni_gen2_q #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_tx_acc && w_dest_ok),
    .i_data  ({w_dest + L_OFF, gpu_data_in[PW-1:0]}),
    .i_ready (router_ready_in),
    .o_ready (gpu_ready_out),
    .o_valid (router_valid_out),
    .o_data  (router_data_out),
    .o_level (tx_level)
  );
  ni_gen2_q #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rx_acc && w_hit),
    .i_data  ({w_hdr - L_OFF, router_data_in[PW-1:0]}),
    .i_ready (gpu_ready_in),
    .o_ready (router_ready_out),
    .o_valid (gpu_valid_out),
    .o_data  (gpu_data_out),
    .o_level (rx_level)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_drop <= '0;
      r_mis  <= '0;
    end else begin
      if (w_tx_acc && !w_dest_ok && r_drop != '1) r_drop <= r_drop + 1'b1;
      if (w_rx_acc && !w_hit && r_mis != '1) r_mis <= r_mis + 1'b1;
    end
endmodule

// File: tb/tb_ni_gen2.sv
// tb_ni_gen2: directed and randomized checks of ni_gen2 against a queue-based reference model
module tb_ni_gen2;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] gdi = '0, rdo, rdi = '0, gdo;
  logic        gvi = 1'b0, gro, rvo, rri = 1'b0, rvi = 1'b0, rro, gvo, gri = 1'b0;
  logic [3:0]  tx_level, rx_level;
  logic [7:0]  drop_cnt, misroute_cnt;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ni_gen2 dut (
    .clk(clk), .reset(reset),
    .gpu_data_in(gdi), .gpu_valid_in(gvi), .gpu_ready_out(gro),
    .router_data_out(rdo), .router_valid_out(rvo), .router_ready_in(rri),
    .router_data_in(rdi), .router_valid_in(rvi), .router_ready_out(rro),
    .gpu_data_out(gdo), .gpu_valid_out(gvo), .gpu_ready_in(gri),
    .tx_level(tx_level), .rx_level(rx_level),
    .drop_cnt(drop_cnt), .misroute_cnt(misroute_cnt)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    gvi = 1'b0; rvi = 1'b0; rri = 1'b0; gri = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [59:0] obs;
    reset = 1'b1;
    #12;
    obs = {rvo, gvo, rdo, gdo, gro, rro, tx_level, rx_level, drop_cnt, misroute_cnt};
    n_cmp++;
    if (obs !== {1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 4'd0, 4'd0, 8'd0, 8'd0}) begin
      n_err++; $display("FAIL reset_state: got %h expected %h", obs,
        {1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 4'd0, 4'd0, 8'd0, 8'd0});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_tx();
    @(negedge clk);
    rri = 1'b1; gdi = 16'h3A05; gvi = 1'b1;
    @(negedge clk);
    gvi = 1'b0;
    n_cmp++;
    if (rvo !== 1'b0) begin n_err++; $display("FAIL tx_latency_early: got %b expected 0", rvo); end
    @(negedge clk);
    n_cmp++;
    if ({rvo, rdo} !== {1'b1, 16'h4605}) begin
      n_err++; $display("FAIL tx_single_out: got %b/%h expected 1/4605", rvo, rdo);
    end
    @(negedge clk);
    n_cmp++;
    if ({rvo, drop_cnt} !== {1'b0, 8'd0}) begin
      n_err++; $display("FAIL tx_single_pulse: got valid %b drop %0d expected 0/0", rvo, drop_cnt);
    end
  endtask

  task automatic test_backpressure();
    int got = 0;
    rri = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      gvi = 1'b1; gdi = 16'h1400 | 16'(i);
    end
    @(negedge clk);
    gvi = 1'b0;
    n_cmp++;
    if ({gro, tx_level, rvo, rdo} !== {1'b1, 4'd7, 1'b1, 16'h2000}) begin
      n_err++; $display("FAIL bp_eight: got rdy %b lvl %0d v %b d %h expected 1/7/1/2000", gro, tx_level, rvo, rdo);
    end
    gvi = 1'b1; gdi = 16'h1408;
    @(negedge clk);
    gdi = 16'h1409;
    n_cmp++;
    if ({gro, tx_level} !== {1'b0, 4'd8}) begin
      n_err++; $display("FAIL bp_full: got rdy %b lvl %0d expected 0/8", gro, tx_level);
    end
    repeat (3) @(negedge clk);
    gvi = 1'b0;
    n_cmp++;
    if ({gro, tx_level, rvo, rdo, drop_cnt} !== {1'b0, 4'd8, 1'b1, 16'h2000, 8'd0}) begin
      n_err++; $display("FAIL bp_stall_stable: got rdy %b lvl %0d v %b d %h drop %0d expected 0/8/1/2000/0",
        gro, tx_level, rvo, rdo, drop_cnt);
    end
    rri = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (rvo) begin
        n_cmp++;
        if (rdo !== (16'h2000 | 16'(got))) begin
          n_err++; $display("FAIL bp_order: got %h expected %h", rdo, 16'h2000 | 16'(got));
        end
        got++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (got != 9) begin n_err++; $display("FAIL bp_count: got %0d expected 9", got); end
  endtask

  task automatic test_invalid_dest();
    bit seen = 1'b0;
    rri = 1'b1;
    @(negedge clk);
    gvi = 1'b1; gdi = 16'h0001;
    @(negedge clk);
    gdi = 16'h8405;
    @(negedge clk);
    gvi = 1'b0;
    for (int c = 0; c < 3; c++) begin
      seen |= rvo;
      @(negedge clk);
    end
    n_cmp++;
    if ({seen, drop_cnt} !== {1'b0, 8'd2}) begin
      n_err++; $display("FAIL drop_two: got out %b drop %0d expected 0/2", seen, drop_cnt);
    end
    for (int i = 0; i < 300; i++) begin
      gvi = 1'b1;
      gdi[15:10] = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(33, 63));
      gdi[9:0] = 10'($urandom);
      @(negedge clk);
    end
    gvi = 1'b0;
    n_cmp++;
    if ({drop_cnt, tx_level, rvo} !== {8'd255, 4'd0, 1'b0}) begin
      n_err++; $display("FAIL drop_saturate: got drop %0d lvl %0d v %b expected 255/0/0", drop_cnt, tx_level, rvo);
    end
  endtask

  task automatic test_rx();
    bit seen = 1'b0;
    gri = 1'b1;
    @(negedge clk);
    rdi = 16'h4605; rvi = 1'b1;
    @(negedge clk);
    rvi = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({gvo, gdo} !== {1'b1, 16'h3A05}) begin
      n_err++; $display("FAIL rx_match: got %b/%h expected 1/3a05", gvo, gdo);
    end
    @(negedge clk);
    rdi = 16'h2001; rvi = 1'b1;
    @(negedge clk);
    rvi = 1'b0;
    for (int c = 0; c < 3; c++) begin
      seen |= gvo;
      @(negedge clk);
    end
    n_cmp++;
    if ({seen, misroute_cnt, rx_level} !== {1'b0, 8'd1, 4'd0}) begin
      n_err++; $display("FAIL rx_misroute: got out %b mis %0d lvl %0d expected 0/1/0", seen, misroute_cnt, rx_level);
    end
  endtask

  task automatic test_rx_full();
    int got = 0;
    gri = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rro !== (i < 9)) begin
        n_err++; $display("FAIL rx_full_ready[%0d]: got %b expected %b", i, rro, i < 9);
      end
      rvi = 1'b1; rdi = 16'h4400 | 16'(i);
    end
    @(negedge clk);
    rvi = 1'b0;
    n_cmp++;
    if ({rx_level, gvo, misroute_cnt} !== {4'd8, 1'b1, 8'd1}) begin
      n_err++; $display("FAIL rx_full_state: got lvl %0d v %b mis %0d expected 8/1/1", rx_level, gvo, misroute_cnt);
    end
    gri = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (gvo) begin
        n_cmp++;
        if (gdo !== (16'h3800 | 16'(got))) begin
          n_err++; $display("FAIL rx_full_order: got %h expected %h", gdo, 16'h3800 | 16'(got));
        end
        got++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (got != 9) begin n_err++; $display("FAIL rx_full_count: got %0d expected 9", got); end
  endtask

  task automatic test_reset_mid();
    logic [59:0] obs;
    do_reset();
    rri = 1'b0; gri = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gvi = 1'b1; rvi = 1'b1;
      gdi = (i < 5) ? (16'h1400 | 16'(i)) : 16'h0001;
      rdi = (i < 5) ? (16'h4400 | 16'(i)) : 16'h2001;
    end
    @(negedge clk);
    gvi = 1'b0; rvi = 1'b0;
    n_cmp++;
    if ({tx_level, rx_level, rvo, gvo, drop_cnt, misroute_cnt} !== {4'd4, 4'd4, 1'b1, 1'b1, 8'd1, 8'd1}) begin
      n_err++; $display("FAIL mid_prefill: got %0d %0d %b %b %0d %0d expected 4 4 1 1 1 1",
        tx_level, rx_level, rvo, gvo, drop_cnt, misroute_cnt);
    end
    #2 reset = 1'b1;
    #1;
    obs = {rvo, gvo, rdo, gdo, gro, rro, tx_level, rx_level, drop_cnt, misroute_cnt};
    n_cmp++;
    if (obs !== {1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 4'd0, 4'd0, 8'd0, 8'd0}) begin
      n_err++; $display("FAIL mid_reset_async: got %h", obs);
    end
    @(negedge clk);
    reset = 1'b0;
    rri = 1'b1; gri = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rvo, gvo, tx_level, rx_level} !== {1'b0, 1'b0, 4'd0, 4'd0}) begin
      n_err++; $display("FAIL mid_reset_discard: got v %b %b lvl %0d %0d expected 0 0 0 0", rvo, gvo, tx_level, rx_level);
    end
  endtask

  // Reference: each path holds an ordered queue of flits still owed to the consumer;
  // the head is in the output register when 'ov' is set, the rest sit in the FIFO.
  task automatic test_random();
    logic [15:0] tq[$], rq[$];
    bit tov = 0, rov = 0;
    int mdrop = 0, mmis = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int tf, rf, pr, r, d, h;
      bit tacc, racc, tload, rload;
      @(negedge clk);
      tf = tq.size() - int'(tov);
      rf = rq.size() - int'(rov);
      n_cmp++;
      if ({gro, int'(tx_level), rvo} !== {tf < 8, tf, tov}) begin
        n_err++; $display("FAIL rnd_tx_state@%0d: got rdy %b lvl %0d v %b expected %b %0d %b", c, gro, tx_level, rvo, tf < 8, tf, tov);
      end
      n_cmp++;
      if ({rro, int'(rx_level), gvo} !== {rf < 8, rf, rov}) begin
        n_err++; $display("FAIL rnd_rx_state@%0d: got rdy %b lvl %0d v %b expected %b %0d %b", c, rro, rx_level, gvo, rf < 8, rf, rov);
      end
      if (tov) begin
        n_cmp++;
        if (rdo !== tq[0]) begin n_err++; $display("FAIL rnd_tx_data@%0d: got %h expected %h", c, rdo, tq[0]); end
      end
      if (rov) begin
        n_cmp++;
        if (gdo !== rq[0]) begin n_err++; $display("FAIL rnd_rx_data@%0d: got %h expected %h", c, gdo, rq[0]); end
      end
      n_cmp++;
      if ({int'(drop_cnt), int'(misroute_cnt)} !== {mdrop, mmis}) begin
        n_err++; $display("FAIL rnd_counters@%0d: got %0d %0d expected %0d %0d", c, drop_cnt, misroute_cnt, mdrop, mmis);
      end
      pr = (c / 500 % 3 == 0) ? 90 : (c / 500 % 3 == 1) ? 20 : 50;
      rri = $urandom_range(0, 99) < pr;
      gri = $urandom_range(0, 99) < pr;
      gvi = $urandom_range(0, 3) != 0;
      rvi = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 9);
      gdi[15:10] = (r == 0) ? 6'd0 : (r == 1) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(1, 32));
      gdi[9:0] = 10'($urandom);
      rdi[15:10] = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'd17;
      rdi[9:0] = 10'($urandom);
      @(posedge clk);
      tacc = gvi && tf < 8;
      racc = rvi && rf < 8;
      tload = tf > 0 && (!tov || rri);
      rload = rf > 0 && (!rov || gri);
      if (tov && rri) begin void'(tq.pop_front()); tov = 0; end
      if (rov && gri) begin void'(rq.pop_front()); rov = 0; end
      if (tload) tov = 1;
      if (rload) rov = 1;
      d = int'(gdi[15:10]);
      h = int'(rdi[15:10]);
      if (tacc) begin
        if (d >= 1 && d <= 32) tq.push_back(16'((d + 3) * 1024 + int'(gdi[9:0])));
        else if (mdrop < 255) mdrop++;
      end
      if (racc) begin
        if (h == 14 + 3) rq.push_back(16'(14 * 1024 + int'(rdi[9:0])));
        else if (mmis < 255) mmis++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_backpressure();
    test_invalid_dest();
    test_rx();
    test_rx_full();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ni_gen2.md
Name: ni_gen2

Overview:
- Second-generation GPU network interface: sits between one GPU endpoint and its leaf router port in the AXI-NoC fabric.
- TX path: translates GPU destination ID to routing header (group+leaf), buffers in a parametrised FIFO, drives router with a valid/ready handshake that holds data until accepted.
- RX path: filters by local address, translates header back to GPU ID, buffers, drives GPU with full backpressure.
- Adds over gen1: router-side ready, invalid-destination drop, misroute detection, saturating statistics counters, occupancy outputs.

Parameters:
- GPU_ID, 14, local GPU ID (1..NUM_GPUS)
- DATA_W, 16, flit width; header occupies [DATA_W-1 -: ID_W]
- ID_W, 6, header/ID field width
- NUM_GPUS, 32, valid IDs are 1..NUM_GPUS
- ADDR_OFFSET, 3, routing addr = ID + ADDR_OFFSET (ID 1 -> 6'b000100, ID 32 -> 6'b100011)
- FIFO_DEPTH, 8, entries per FIFO; power of two, >= 2
- CNT_W, 8, statistics counter width

Ports:
- clk  in  1  clock
- reset  in  1  reset
- gpu_data_in  in  DATA_W  GPU TX flit {dest_id, payload}
- gpu_valid_in  in  1  TX valid
- gpu_ready_out  out  1  TX ready = !tx_full
- router_data_out  out  DATA_W  flit {routing_addr, payload}
- router_valid_out  out  1  flit valid
- router_ready_in  in  1  router accepts
- router_data_in  in  DATA_W  RX flit {routing_addr, payload}
- router_valid_in  in  1  RX valid
- router_ready_out  out  1  RX ready = !rx_full
- gpu_data_out  out  DATA_W  RX flit {src-translated id, payload}
- gpu_valid_out  out  1  RX valid
- gpu_ready_in  in  1  GPU accepts
- tx_level  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy
- rx_level  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
- drop_cnt  out  CNT_W  TX flits dropped (invalid dest)
- misroute_cnt  out  CNT_W  RX flits discarded (header != local addr)

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. All pointers, counts, counters -> 0; router_valid_out=0, gpu_valid_out=0, router_data_out=0, gpu_data_out=0; gpu_ready_out=1, router_ready_out=1 after reset. Reset mid-transfer discards all buffered flits.
- Handshake: a transfer occurs on a rising edge where valid && ready. A held valid output keeps data stable until its ready is seen high.
- TX accept: on gpu_valid_in && gpu_ready_out:
  - dest_id in 1..NUM_GPUS: push {dest_id+ADDR_OFFSET, payload}.
  - otherwise: no push; drop_cnt += 1, saturating at all-ones.
- TX output stage: a single output register. It loads from the FIFO head when (!router_valid_out || router_ready_in) && !tx_empty; it clears valid when consumed with the FIFO empty.
  - Latency: accepted at edge k -> router_valid_out high after edge k+1.
  - Sustained throughput: 1 flit/cycle.
- RX accept: on router_valid_in && router_ready_out:
  - header == GPU_ID+ADDR_OFFSET: push {header-ADDR_OFFSET, payload}.
  - otherwise: discard; misroute_cnt += 1, saturating.
- RX output: same output-register rules as TX, on gpu_valid_out/gpu_ready_in.
- FIFOs: pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Count is one bit wider, so full == FIFO_DEPTH is representable. Simultaneous push and pop leaves the count unchanged.
- Full: ready deasserts combinationally from the count. Push is not accepted at full, even if a pop happens the same cycle.
- Empty: the output stage does not load.
- tx_level/rx_level report FIFO count only, excluding the output register.
- Paths are independent; no loopback. A self-addressed TX flit is forwarded to the router.

Test Plan:
- Single TX: gpu_data_in=16'h3A05 (dest 14), router_ready_in=1 -> router_data_out=16'h4605, valid 2 edges after accept, 1-cycle pulse; drop_cnt=0.
- Backpressure: push 8 flits dest 5 (16'h1401) with router_ready_in=0 -> 1 flit in output reg, tx_level=7. Push 8th/9th until gpu_ready_out=0 at tx_level=8. Release ready -> 9 flits 16'h2001 in order, no loss or duplication, router_data_out stable while stalled.
- Invalid dest: gpu_data_in=16'h0001 and dest 33 -> no router output, drop_cnt=2. Hammer 300 invalid flits with CNT_W=8 -> drop_cnt=255.
- RX match/mismatch: router_data_in=16'h4605 -> gpu_data_out=16'h3A05. router_data_in=16'h2001 -> discarded, misroute_cnt=1.
- RX full: gpu_ready_in=0, stream 10 matching flits -> router_ready_out=0 after 9 accepted. Then gpu_ready_in=1 -> all 9 delivered in order.
- Reset mid-operation: assert reset with both FIFOs half full and outputs valid -> next cycle all valids 0, levels 0, counters 0, both readies 1.
